// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU control sequencer.
// Opcodes, FSM state encoding, ALU op codes and bus widths.
package cpu_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 12;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_STA  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_A,
    S_MEM_B,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  // ALU opcodes are contiguous, so the op code is the offset from ADD.
  function automatic logic [1:0] alu_of(logic [3:0] op);
    return 2'(op - OP_ADD);
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Memory req/ack bus between the sequencer and memory.
// Ports: mem_req, mem_we, mem_addr (master out); mem_ack, mem_rdata (master in).
interface cpu_ctrl_seq_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cpu_pc.sv
// Program counter: load has priority over increment, wraps at 2^W.
// Ports: clk, rst, inc, load, d (load value), q (current pc).
module cpu_pc #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
    else if (inc)  q <= q + W'(1);
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute sequencer: drives memory bus, A/B load strobes, ALU op.
// Ports: clk, rst, start, mem (bus master), alu_zero, pc, ir, loadA, loadB,
// a_src, alu_op, halted, illegal; timeout_err with CPU_CTRL_TIMEOUT_EN.
module cpu_ctrl_seq
  import cpu_pkg::*;
`ifdef CPU_CTRL_TIMEOUT_EN
#(
  parameter int TIMEOUT = TIMEOUT_DEF
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  cpu_ctrl_seq_if.master     mem,
  input  logic               alu_zero,
  output logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  ir,
  output logic               loadA,
  output logic               loadB,
  output logic               a_src,
  output logic [1:0]         alu_op,
  output logic               halted,
`ifdef CPU_CTRL_TIMEOUT_EN
  output logic               timeout_err,
`endif
  output logic               illegal
);

  state_t            state, nxt;
  logic              req, we;
  logic [ADDR_W-1:0] addr;
  logic              pc_inc, pc_ld, ir_ld, ill_set;
  logic [3:0]        opc;

  assign opc          = ir[15:12];
  assign mem.mem_req  = req;
  assign mem.mem_we   = we;
  assign mem.mem_addr = addr;

  cpu_pc #(.W(ADDR_W)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .inc  (pc_inc),
    .load (pc_ld),
    .d    (ir[ADDR_W-1:0]),
    .q    (pc)
  );

`ifdef CPU_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wcnt;
  logic       to_set;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (ir_ld)   ir      <= mem.mem_rdata;
      if (ill_set) illegal <= 1'b1;
    end
  end

`ifdef CPU_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (nxt != state)             wcnt <= '0;
      else if (req && !mem.mem_ack) wcnt <= wcnt + 8'd1;
      if (to_set) timeout_err <= 1'b1;
    end
  end
`endif

  always_comb begin
    nxt     = state;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    loadA   = 1'b0;
    loadB   = 1'b0;
    a_src   = 1'b0;
    alu_op  = 2'd0;
    halted  = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    ir_ld   = 1'b0;
    ill_set = 1'b0;
`ifdef CPU_CTRL_TIMEOUT_EN
    to_set  = 1'b0;
`endif
    unique case (state)
      S_IDLE: if (start) nxt = S_FETCH;
      S_FETCH: begin
        req  = 1'b1;
        addr = pc;
        if (mem.mem_ack) begin
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
          nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        nxt = S_FETCH;
        unique case (1'b1)
          opc == OP_NOP:               ;
          opc == OP_LDA:               nxt = S_MEM_A;
          opc == OP_LDB:               nxt = S_MEM_B;
          opc inside {[OP_ADD:OP_OR]}: nxt = S_EXEC;
          opc == OP_STA:               nxt = S_STORE;
          opc == OP_JMP:               pc_ld = 1'b1;
          opc == OP_JZ:                pc_ld = alu_zero;
          opc == OP_HALT:              nxt = S_HALT;
          default:                     ill_set = 1'b1;
        endcase
      end
      // A/B strobes are Mealy on ack so the load lands with valid read data.
      S_MEM_A: begin
        req   = 1'b1;
        addr  = ir[ADDR_W-1:0];
        loadA = mem.mem_ack;
        if (mem.mem_ack) nxt = S_FETCH;
      end
      S_MEM_B: begin
        req   = 1'b1;
        addr  = ir[ADDR_W-1:0];
        loadB = mem.mem_ack;
        if (mem.mem_ack) nxt = S_FETCH;
      end
      S_EXEC: begin
        loadA  = 1'b1;
        a_src  = 1'b1;
        alu_op = alu_of(opc);
        nxt    = S_FETCH;
      end
      S_STORE: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = ir[ADDR_W-1:0];
        if (mem.mem_ack) nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_IDLE;
    endcase
`ifdef CPU_CTRL_TIMEOUT_EN
    if (req && !mem.mem_ack && wcnt == TO_LAST) begin
      nxt    = S_HALT;
      to_set = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq with a memory responder and event scoreboard.
// Expected bus/strobe events are queued with stimulus and matched on output.
module tb_cpu_ctrl_seq;
  import cpu_pkg::*;

  localparam logic [2:0] K_F = 3'd0, K_LA = 3'd1, K_LB = 3'd2;
  localparam logic [2:0] K_EX = 3'd3, K_ST = 3'd4, K_BAD = 3'd6;

  typedef struct packed {
    logic [2:0]  k;
    logic [11:0] a;
    logic        s;
    logic [1:0]  op;
  } ev_t;

  logic clk = 1'b0;
  logic rst, start, alu_zero;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic loadA, loadB, a_src, halted, illegal;
  logic [1:0] alu_op;
`ifdef CPU_CTRL_TIMEOUT_EN
  logic timeout_err;
`endif

  cpu_ctrl_seq_if m();

  cpu_ctrl_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem      (m),
    .alu_zero (alu_zero),
    .pc       (pc),
    .ir       (ir),
    .loadA    (loadA),
    .loadB    (loadB),
    .a_src    (a_src),
    .alu_op   (alu_op),
    .halted   (halted),
`ifdef CPU_CTRL_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  int   dly = 0;
  logic spur = 1'b0;
  logic ack_off = 1'b0;
  int   total = 0;
  int   bad = 0;
  ev_t  expq[$];
  ev_t  obs[$];

  // Memory responder: ack after dly wait cycles of an active request.
  initial begin
    int wc;
    wc = 0;
    m.mem_ack = 1'b0;
    m.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (m.mem_req && !ack_off) begin
        if (wc >= dly) begin
          m.mem_ack = 1'b1;
          m.mem_rdata = mem[m.mem_addr];
          wc = 0;
        end else begin
          m.mem_ack = 1'b0;
          wc++;
        end
      end else begin
        m.mem_ack = spur;
        wc = 0;
      end
    end
  end

  // Event monitor: completed transfers and load strobes.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        e.a = m.mem_addr;
        e.s = a_src;
        e.op = alu_op;
        e.k = K_BAD;
        if (loadA && loadB) obs.push_back(e);
        else if (m.mem_req && m.mem_ack) begin
          e.k = m.mem_we ? K_ST : loadA ? K_LA : loadB ? K_LB : K_F;
          obs.push_back(e);
        end else if (loadA || loadB) begin
          e.k = K_EX;
          obs.push_back(e);
        end
      end
    end
  end

  function automatic ev_t mk(logic [2:0] k, logic [11:0] a,
                             logic s, logic [1:0] op);
    ev_t e;
    e.k = k; e.a = a; e.s = s; e.op = op;
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, o, e);
    end
  endtask

  task automatic drain(string tag);
    ev_t e, o;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      if (obs.size() == 0) o = '1;
      else o = obs.pop_front();
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s ev got=%h want=%h", tag, o, e);
      end
    end
    chk({tag, "_extra"}, obs.size(), 0);
    obs.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    obs.delete();
    step();
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halt(string tag, int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      step();
      n++;
    end
    chk(tag, halted, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    alu_zero = 1'b0;
    clr_mem();
    step();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_req", m.mem_req, 0);
    chk("rst_halt", halted, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_strobes", {loadA, loadB, a_src, alu_op}, 0);
    rst = 1'b0;
    step();

    // Program: LDA, LDB, ADD, STA, HALT with zero-wait ack.
    mem[0] = 16'h1005; mem[1] = 16'h2006; mem[2] = 16'h3000;
    mem[3] = 16'h7007; mem[4] = 16'hF000;
    mem[5] = 16'h00FE; mem[6] = 16'h0002;
    expq.push_back(mk(K_F, 12'h000, 0, 0));
    expq.push_back(mk(K_LA, 12'h005, 0, 0));
    expq.push_back(mk(K_F, 12'h001, 0, 0));
    expq.push_back(mk(K_LB, 12'h006, 0, 0));
    expq.push_back(mk(K_F, 12'h002, 0, 0));
    expq.push_back(mk(K_EX, 12'h000, 1, 0));
    expq.push_back(mk(K_F, 12'h003, 0, 0));
    expq.push_back(mk(K_ST, 12'h007, 0, 0));
    expq.push_back(mk(K_F, 12'h004, 0, 0));
    go();
    wait_halt("p1_halt", 60);
    chk("p1_pc", pc, 12'h005);
    drain("p1");

    // Delayed ack on LDA and a spurious ack while idle.
    do_reset();
    clr_mem();
    mem[0] = 16'h1005; mem[1] = 16'hF000;
    spur = 1'b1;
    step();
    step();
    chk("spur_req", m.mem_req, 0);
    chk("spur_pc", pc, 0);
    chk("spur_ir", ir, 0);
    spur = 1'b0;
    step();
    drain("spur");
    dly = 3;
    expq.push_back(mk(K_F, 12'h000, 0, 0));
    expq.push_back(mk(K_LA, 12'h005, 0, 0));
    expq.push_back(mk(K_F, 12'h001, 0, 0));
    go();
    n = 0;
    while (!(m.mem_req && m.mem_addr == 12'h005) && n < 60) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("dly_req", m.mem_req, 1);
      chk("dly_addr", m.mem_addr, 12'h005);
      chk("dly_loadA", loadA, (i == 3) ? 1 : 0);
    end
    wait_halt("dly_halt", 60);
    drain("dly");
    dly = 0;

    // JZ taken.
    do_reset();
    clr_mem();
    mem[0] = 16'h9100; mem[12'h100] = 16'hF000;
    alu_zero = 1'b1;
    expq.push_back(mk(K_F, 12'h000, 0, 0));
    expq.push_back(mk(K_F, 12'h100, 0, 0));
    go();
    wait_halt("jz1_halt", 40);
    chk("jz1_pc", pc, 12'h101);
    drain("jz1");

    // JZ not taken.
    do_reset();
    mem[1] = 16'hF000;
    alu_zero = 1'b0;
    expq.push_back(mk(K_F, 12'h000, 0, 0));
    expq.push_back(mk(K_F, 12'h001, 0, 0));
    go();
    wait_halt("jz0_halt", 40);
    chk("jz0_pc", pc, 12'h002);
    drain("jz0");

    // JMP from 0xFFF: pc wraps on fetch, then jump target wins.
    do_reset();
    clr_mem();
    mem[0] = 16'h8FFF; mem[12'hFFF] = 16'h8020; mem[12'h020] = 16'hF000;
    expq.push_back(mk(K_F, 12'h000, 0, 0));
    expq.push_back(mk(K_F, 12'hFFF, 0, 0));
    expq.push_back(mk(K_F, 12'h020, 0, 0));
    go();
    n = 0;
    while (ir !== 16'h8020 && n < 40) begin
      step();
      n++;
    end
    chk("wrap_pc", pc, 12'h000);
    wait_halt("wrap_halt", 40);
    chk("wrap_end_pc", pc, 12'h021);
    drain("wrap");

    // Illegal opcode, then start is ignored in HALT.
    do_reset();
    clr_mem();
    mem[0] = 16'hB000; mem[1] = 16'hF000;
    expq.push_back(mk(K_F, 12'h000, 0, 0));
    expq.push_back(mk(K_F, 12'h001, 0, 0));
    go();
    wait_halt("ill_halt", 40);
    chk("ill_flag", illegal, 1);
    chk("ill_pc", pc, 12'h002);
    start = 1'b1;
    step();
    step();
    step();
    start = 1'b0;
    chk("halt_stays", halted, 1);
    chk("halt_pc", pc, 12'h002);
    chk("ill_sticky", illegal, 1);
    drain("ill");

    // Async reset in the middle of a STORE wait.
    do_reset();
    clr_mem();
    mem[0] = 16'h7007;
    dly = 5;
    expq.push_back(mk(K_F, 12'h000, 0, 0));
    go();
    n = 0;
    while (!m.mem_we && n < 60) begin
      step();
      n++;
    end
    step();
    chk("st_req", m.mem_req, 1);
    chk("st_we", m.mem_we, 1);
    chk("st_addr", m.mem_addr, 12'h007);
    #4;
    rst = 1'b1;
    #1;
    chk("arst_req", m.mem_req, 0);
    chk("arst_we", m.mem_we, 0);
    chk("arst_loadA", loadA, 0);
    chk("arst_addr", m.mem_addr, 0);
    chk("arst_pc", pc, 0);
    step();
    rst = 1'b0;
    step();
    chk("arst_idle", m.mem_req, 0);
    drain("arst");
    dly = 0;
    mem[0] = 16'hF000;
    expq.push_back(mk(K_F, 12'h000, 0, 0));
    go();
    wait_halt("arst_halt", 40);
    chk("arst_end_pc", pc, 12'h001);
    drain("arst2");

`ifdef CPU_CTRL_TIMEOUT_EN
    // Ack withheld in FETCH: HALT after the last allowed wait cycle.
    do_reset();
    ack_off = 1'b1;
    chk("to_clear", timeout_err, 0);
    go();
    n = 1;
    while (!halted && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, 16);
    chk("to_halt", halted, 1);
    chk("to_err", timeout_err, 1);
    ack_off = 1'b0;
    obs.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
